// File: rtl/core_sequencer_if.sv
// Memory handshake bundle for the core sequencer: instruction fetch and data access.
interface core_sequencer_if;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ready, imem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ready, imem_rdata, dmem_ready
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/mem/writeback control,
// PC update, and trap handling for illegal opcodes, misaligned targets and bus timeouts.
module core_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    core_sequencer_if.master    bus,
    output logic [31:0]         pc,
    input  logic [31:0]         next_addr,
    input  logic                Z,
    input  logic                C,
    input  logic                N,
    input  logic                V,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [3:0]          alu_op,
    output logic                u_control,
    output logic                load_pc,
    output logic                mem_read,
    output logic                mem_read_sext,
    output logic [3:0]          iobytes,
    output logic                r,
    output logic                i,
    output logic                s,
    output logic                sb,
    output logic                u,
    output logic                uj,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] CAUSE_ILLEGAL   = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b11;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cause_q, cause_d;
    logic [3:0]         flags_q, flags_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       dec_r, dec_i, dec_s, dec_sb, dec_u, dec_uj;
    logic       dec_uctl, is_load, is_store, is_alui, is_jal, is_jalr, legal;
    logic       active, in_wb, imem_req_int, dmem_req_int, taken;
    logic [3:0] alu_raw, iob_raw;
    logic [31:0] target;
    logic       unused_ir;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign unused_ir = ^{ir_q[31], ir_q[29:25]};

    // Branch condition from flags captured at the end of EXECUTE ({Z,C,N,V}).
    function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] flg);
        logic res;
        case (f3)
            3'b000:  res = flg[3];
            3'b001:  res = ~flg[3];
            3'b100:  res = flg[1] ^ flg[0];
            3'b101:  res = ~(flg[1] ^ flg[0]);
            3'b110:  res = ~flg[2];
            3'b111:  res = flg[2];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Instruction class decode from the latched IR.
    always_comb begin
        dec_r    = 1'b0;
        dec_i    = 1'b0;
        dec_s    = 1'b0;
        dec_sb   = 1'b0;
        dec_u    = 1'b0;
        dec_uj   = 1'b0;
        dec_uctl = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_alui  = 1'b0;
        is_jal   = 1'b0;
        is_jalr  = 1'b0;
        legal    = 1'b1;
        case (opcode)
            OP_R:      dec_r = 1'b1;
            OP_ALUI:   begin dec_i = 1'b1; is_alui = 1'b1; end
            OP_LOAD:   begin dec_i = 1'b1; is_load = 1'b1; end
            OP_STORE:  begin dec_s = 1'b1; is_store = 1'b1; end
            OP_BRANCH: begin
                dec_sb = 1'b1;
                // funct3 010/011 are not branch encodings
                if (funct3[2:1] == 2'b01) legal = 1'b0;
            end
            OP_LUI:    begin dec_u = 1'b1; dec_uctl = 1'b1; end
            OP_AUIPC:  dec_u = 1'b1;
            OP_JAL:    begin dec_uj = 1'b1; is_jal = 1'b1; end
            OP_JALR:   begin dec_i = 1'b1; is_jalr = 1'b1; end
            default:   legal = 1'b0;
        endcase
    end

    // ALU opcode and byte-lane selection for the decoded instruction.
    always_comb begin
        alu_raw = 4'b0000;
        iob_raw = 4'b0000;
        if (dec_r)
            alu_raw = {ir_q[30], funct3};
        else if (is_alui)
            alu_raw = {(funct3 == 3'b101) ? ir_q[30] : 1'b0, funct3};
        else if (dec_sb)
            alu_raw = 4'b1000;
        if (is_load || is_store) begin
            case (funct3[1:0])
                2'b00:   iob_raw = 4'b0001;
                2'b01:   iob_raw = 4'b0011;
                2'b10:   iob_raw = 4'b1111;
                default: iob_raw = 4'b0000;
            endcase
        end
    end

    assign taken = branch_taken(funct3, flags_q);

    // Next PC: relative for JAL/taken branch, absolute for JALR, sequential otherwise.
    always_comb begin
        target = pc_q + 32'd4;
        if (is_jal || (dec_sb && taken))
            target = pc_q + next_addr;
        else if (is_jalr)
            target = {next_addr[31:1], 1'b0};
    end

    // Sequencer next-state, wait counter and trap cause.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        cnt_d        = cnt_q;
        cause_d      = cause_q;
        flags_d      = flags_q;
        imem_req_int = 1'b0;
        dmem_req_int = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_int = 1'b1;
                if (bus.imem_ready) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXECUTE: begin
                flags_d = {Z, C, N, V};
                if (is_load || is_store) begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM: begin
                dmem_req_int = 1'b1;
                if (bus.dmem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITEBACK: begin
                if (target[1:0] != 2'b00) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_MISALIGN;
                end else begin
                    pc_d    = target;
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            cnt_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // ALU flag capture; pure data, no reset needed.
    always_ff @(posedge clk) begin
        flags_q <= flags_d;
    end

    assign active = !rst && legal &&
                    (state_q == S_DECODE || state_q == S_EXECUTE ||
                     state_q == S_MEM    || state_q == S_WRITEBACK);
    assign in_wb  = !rst && (state_q == S_WRITEBACK);

    assign bus.imem_req  = imem_req_int & ~rst;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = dmem_req_int & ~rst;
    assign bus.dmem_we   = dmem_req_int & ~rst & dec_s;

    assign pc            = pc_q;
    assign rs1           = ir_q[19:15];
    assign rs2           = ir_q[24:20];
    assign rd            = (in_wb && (dec_r || dec_i || dec_u || dec_uj)) ? ir_q[11:7] : 5'd0;
    assign r             = active & dec_r;
    assign i             = active & dec_i;
    assign s             = active & dec_s;
    assign sb            = active & dec_sb;
    assign u             = active & dec_u;
    assign uj            = active & dec_uj;
    assign u_control     = active & dec_uctl;
    assign mem_read      = active & is_load;
    assign mem_read_sext = active & (is_load | is_store) & ~ir_q[14];
    assign load_pc       = active & (is_jal | is_jalr | dec_sb);
    assign alu_op        = active ? alu_raw : 4'b0000;
    assign iobytes       = active ? iob_raw : 4'b0000;
    assign trap          = !rst && (state_q == S_TRAP);
    assign trap_cause    = trap ? cause_q : 2'b00;
    assign state         = rst ? 3'd0 : state_q;

endmodule
